// File: rtl/osc_freq_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// Holds the FSM state encoding and the gate exponent limits.
package vgaringosc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_t;

  localparam int GATE_MAX_LOG2_DEF = 20;
  localparam int GATE_LOG2_W       = 5;

  // Requested exponents beyond the supported maximum fall back to the maximum.
  function automatic int clamp_log2(input logic [GATE_LOG2_W-1:0] g, input int gmax);
    return (int'(g) > gmax) ? gmax : int'(g);
  endfunction

endpackage

// File: rtl/osc_freq_meter_if.sv
// Control/status bundle between the frequency meter and its register-side master.
interface osc_freq_meter_if
  import vgaringosc_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) ();

  logic [$clog2(NCH)-1:0] chsel;
  logic [GATE_LOG2_W-1:0] gate_log2;
  logic                   continuous;
  logic                   start;
  logic                   stop;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       result;
  logic                   overflow;

  modport master (
    output chsel, gate_log2, continuous, start, stop,
    input  busy, done, result, overflow
  );

  modport slave (
    input  chsel, gate_log2, continuous, start, stop,
    output busy, done, result, overflow
  );

endinterface

// File: rtl/osc_sync_edge.sv
// Two-flop synchroniser for one asynchronous oscillator tap plus a third flop
// that turns the synchronised level into a single-cycle rising-edge pulse.
module osc_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic osc,
  output logic rise
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= osc;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/osc_freq_meter.sv
// Multi-channel oscillator frequency meter: counts rising edges of one selected
// tap over a 2^k clk-cycle window, single-shot or back-to-back.
module osc_freq_meter
  import vgaringosc_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int CNT_W         = 16,
  parameter int GATE_MAX_LOG2 = GATE_MAX_LOG2_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   osc_in,
  osc_freq_meter_if.slave  bus
);

  localparam int              CH_W    = $clog2(NCH);
  localparam int              WIN_W   = (GATE_MAX_LOG2 > 0) ? GATE_MAX_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic e);
    return (e && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
  endfunction

  function automatic logic sat_hit(input logic [CNT_W-1:0] c, input logic e);
    return e && (c == CNT_MAX);
  endfunction

  function automatic logic [WIN_W-1:0] win_end_of(input logic [GATE_LOG2_W-1:0] g);
    return WIN_W'((64'd1 << clamp_log2(g, GATE_MAX_LOG2)) - 64'd1);
  endfunction

  logic [NCH-1:0]   edge_p2;
  state_t           state, state_nxt;
  logic [CH_W-1:0]  ch_q;
  logic [WIN_W-1:0] win_end_q, win_cnt;
  logic             cont_q;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat_q;
  logic             edge_sel, win_last, load, win_done;
  logic             busy_q, done_q, ovf_q;
  logic [CNT_W-1:0] result_q;

  // Every tap is synchronised all the time so a channel switch never sees a stale level.
  for (genvar g = 0; g < NCH; g++) begin : g_sync
    osc_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .osc   (osc_in[g]),
      .rise  (edge_p2[g])
    );
  end

  assign edge_sel = edge_p2[ch_q];
  assign win_last = (win_cnt == win_end_q);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    win_done  = 1'b0;
    case (state)
      IDLE: begin
        load = 1'b1;
        if (bus.start && !bus.stop) state_nxt = ARM;
      end
      ARM:  state_nxt = bus.stop ? IDLE : GATE;
      GATE: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (win_last) begin
          win_done = 1'b1;
          if (!cont_q) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Measurement datapath: settings are re-latched every idle cycle, so the values
  // present on the start edge are the ones used for the whole run.
  always_ff @(posedge clk) begin
    if (load) begin
      ch_q      <= bus.chsel;
      win_end_q <= win_end_of(bus.gate_log2);
      cont_q    <= bus.continuous;
      edge_cnt  <= '0;
      win_cnt   <= '0;
      sat_q     <= 1'b0;
    end else if (state == GATE) begin
      if (win_last) begin
        edge_cnt <= '0;
        win_cnt  <= '0;
        sat_q    <= 1'b0;
      end else begin
        edge_cnt <= sat_inc(edge_cnt, edge_sel);
        win_cnt  <= win_cnt + WIN_W'(1);
        sat_q    <= sat_q | sat_hit(edge_cnt, edge_sel);
      end
    end
  end

  // Output stage: the final-cycle edge is folded into the published count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= win_done;
      if (win_done) begin
        result_q <= sat_inc(edge_cnt, edge_sel);
        ovf_q    <= sat_q | sat_hit(edge_cnt, edge_sel);
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Scenario bench for osc_freq_meter: scoreboard of expected windows, checked when done strobes.
module tb_osc_freq_meter;
  import vgaringosc_pkg::*;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int GMAX  = 12;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    int done_cyc;
    int cnt;
    int tol;
    bit ovf;
  } exp_t;

  exp_t sb[$];

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] osc = '0;
  int             half_ns[NCH];
  int             acc[NCH];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_pass = 0;

  osc_freq_meter_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  osc_freq_meter #(.NCH(NCH), .CNT_W(CNT_W), .GATE_MAX_LOG2(GMAX)) dut (
    .clk    (clk),
    .reset  (reset),
    .osc_in (osc),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator taps toggle on a 10 ns grid offset 3 ns from the clock edges.
  initial begin
    half_ns = '{30, 40, 30, 30};
    acc     = '{0, 0, 0, 0};
    #3;
    forever begin
      #10;
      for (int i = 0; i < NCH; i++) begin
        acc[i] += 10;
        if (acc[i] >= half_ns[i]) begin
          acc[i] = 0;
          osc[i] = ~osc[i];
        end
      end
    end
  end

  task automatic launch(input int ch, input int g, input bit cont, input int period, output int t0);
    exp_t e;
    int   kc, raw;
    @(negedge clk);
    bus.chsel      = ch[$clog2(NCH)-1:0];
    bus.gate_log2  = g[4:0];
    bus.continuous = cont;
    bus.start      = 1'b1;
    t0 = cyc;
    kc  = (g > GMAX) ? GMAX : g;
    raw = (1 << kc) / period;
    e.done_cyc = t0 + (1 << kc) + 2;
    e.cnt      = (raw > CMAX) ? CMAX : raw;
    e.ovf      = (raw > CMAX);
    e.tol      = (raw > CMAX) ? 0 : 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic collect(output bit got, output int at, output int res, output bit ovf, output exp_t e);
    int lim;
    e   = sb.pop_front();
    got = 1'b0;
    at  = -1;
    res = -1;
    ovf = 1'b0;
    lim = e.done_cyc - cyc + 64;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        at  = cyc;
        res = int'(bus.result);
        ovf = bus.overflow;
      end
    end
  endtask

  task automatic test_reset;
    bus.chsel = '0; bus.gate_log2 = '0; bus.continuous = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.overflow} !== 3'b000) $display("FAIL reset_flags: busy/done/ovf=%b required 000", {bus.busy, bus.done, bus.overflow});
    else n_pass++;
    n_checks++;
    if (bus.result !== '0) $display("FAIL reset_result: result=%0d required 0", bus.result);
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    bit got, ovf; int at, res, t0; exp_t e;
    launch(1, 8, 1'b0, 8, t0);
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL single_busy: busy=%b required 1", bus.busy);
    else n_pass++;
    collect(got, at, res, ovf, e);
    n_checks++;
    if (!got || at !== e.done_cyc) $display("FAIL single_latency: done at %0d required %0d (start %0d)", at, e.done_cyc, t0);
    else n_pass++;
    n_checks++;
    if (res < e.cnt - e.tol || res > e.cnt + e.tol) $display("FAIL single_result: result=%0d required %0d+-%0d", res, e.cnt, e.tol);
    else n_pass++;
    n_checks++;
    if (ovf !== e.ovf || bus.busy !== 1'b0) $display("FAIL single_ovf_busy: ovf=%b busy=%b required %b/0", ovf, bus.busy, e.ovf);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit got, ovf; int at, res, t0; exp_t e;
    launch(1, 8, 1'b0, 8, t0);
    void'(sb.pop_back());
    repeat (60) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.overflow} !== 3'b000 || bus.result !== '0)
      $display("FAIL reset_mid: busy/done/ovf=%b result=%0d required 000/0", {bus.busy, bus.done, bus.overflow}, bus.result);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    launch(0, 8, 1'b0, 6, t0);
    collect(got, at, res, ovf, e);
    n_checks++;
    if (!got || at !== e.done_cyc) $display("FAIL post_reset_latency: done at %0d required %0d", at, e.done_cyc);
    else n_pass++;
    n_checks++;
    if (res < e.cnt - e.tol || res > e.cnt + e.tol || ovf !== 1'b0) $display("FAIL post_reset_result: result=%0d ovf=%b required %0d+-%0d/0", res, ovf, e.cnt, e.tol);
    else n_pass++;
  endtask

  task automatic test_min_window;
    bit got, ovf; int at, res, t0; exp_t e;
    launch(1, 0, 1'b0, 8, t0);
    collect(got, at, res, ovf, e);
    n_checks++;
    if (!got || at !== e.done_cyc) $display("FAIL min_window_latency: done at %0d required %0d", at, e.done_cyc);
    else n_pass++;
    n_checks++;
    if (res < 0 || res > 1 || ovf !== 1'b0) $display("FAIL min_window_result: result=%0d ovf=%b required 0..1/0", res, ovf);
    else n_pass++;
  endtask

  task automatic test_saturate;
    bit got, ovf; int at, res, t0; exp_t e;
    half_ns[1] = 20;
    repeat (4) @(negedge clk);
    launch(1, 12, 1'b0, 4, t0);
    collect(got, at, res, ovf, e);
    n_checks++;
    if (!got || res !== e.cnt) $display("FAIL saturate_result: result=%0d required %0d", res, e.cnt);
    else n_pass++;
    n_checks++;
    if (ovf !== e.ovf) $display("FAIL saturate_ovf: ovf=%b required %b", ovf, e.ovf);
    else n_pass++;
    half_ns[1] = 40;
  endtask

  task automatic test_clamp;
    bit got, ovf; int at, res, t0; exp_t e;
    half_ns[2] = 160;
    repeat (4) @(negedge clk);
    launch(2, 31, 1'b0, 32, t0);
    collect(got, at, res, ovf, e);
    n_checks++;
    if (!got || at !== t0 + (1 << GMAX) + 2) $display("FAIL clamp_latency: done at %0d required %0d", at, t0 + (1 << GMAX) + 2);
    else n_pass++;
    n_checks++;
    if (res < e.cnt - e.tol || res > e.cnt + e.tol || ovf !== 1'b0) $display("FAIL clamp_result: result=%0d ovf=%b required %0d+-%0d/0", res, ovf, e.cnt, e.tol);
    else n_pass++;
    half_ns[2] = 30;
  endtask

  task automatic test_continuous;
    bit got, ovf; int at, res, t0, sum; exp_t e, nxt;
    launch(1, 8, 1'b1, 8, t0);
    for (int w = 1; w < 3; w++) begin
      nxt = sb[sb.size() - 1];
      nxt.done_cyc += 256;
      sb.push_back(nxt);
    end
    sum = 0;
    for (int w = 0; w < 3; w++) begin
      collect(got, at, res, ovf, e);
      sum += res;
      n_checks++;
      if (!got || at !== e.done_cyc || bus.busy !== 1'b1) $display("FAIL cont_window%0d: done at %0d busy=%b required %0d/1", w, at, bus.busy, e.done_cyc);
      else n_pass++;
    end
    n_checks++;
    if (sum < 95 || sum > 97) $display("FAIL cont_sum: sum=%0d required 96+-1", sum);
    else n_pass++;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.continuous = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL cont_stop: busy=%b required 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_stop;
    int t0; logic [CNT_W-1:0] prev; bit seen;
    prev = bus.result;
    launch(1, 8, 1'b0, 8, t0);
    void'(sb.pop_back());
    while (cyc < t0 + 2 + 100) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== prev)
      $display("FAIL stop_abort: busy=%b done=%b result=%0d required 0/0/%0d", bus.busy, bus.done, bus.result, prev);
    else n_pass++;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || bus.result !== prev) $display("FAIL stop_quiet: done_seen=%b result=%0d required 0/%0d", seen, bus.result, prev);
    else n_pass++;
  endtask

  task automatic test_ignore_midrun;
    bit got, ovf; int at, res, t0; exp_t e;
    launch(1, 8, 1'b0, 8, t0);
    repeat (60) @(negedge clk);
    bus.start = 1'b1; bus.chsel = '0; bus.gate_log2 = 5'd2; bus.continuous = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    collect(got, at, res, ovf, e);
    n_checks++;
    if (!got || at !== e.done_cyc) $display("FAIL ignore_latency: done at %0d required %0d", at, e.done_cyc);
    else n_pass++;
    n_checks++;
    if (res < e.cnt - e.tol || res > e.cnt + e.tol || bus.busy !== 1'b0) $display("FAIL ignore_result: result=%0d busy=%b required %0d+-%0d/0", res, bus.busy, e.cnt, e.tol);
    else n_pass++;
    bus.continuous = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_reset_mid;
    test_min_window;
    test_saturate;
    test_clamp;
    test_continuous;
    test_stop;
    test_ignore_midrun;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/osc_freq_meter.md
# osc_freq_meter

Parametrised multi-channel frequency meter for the ring-oscillator test die, successor to the fixed `clksel`/`oscdiv` probing path. It takes NCH asynchronous, pre-divided oscillator taps, synchronises each into `clk`, and counts rising edges of one selected channel over a programmable window of 2^k `clk` cycles. It supports single-shot and continuous gating, and reports a saturating edge count with a done strobe. It sits between the oscillator/divider bank and the register/VGA readout logic.

## Interface
Parameters:
- `NCH`, 4: number of oscillator input channels (≥2).
- `CNT_W`, 16: result/edge counter width.
- `GATE_MAX_LOG2`, 20: largest gate exponent; `gate_log2` values above it are clamped to it.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `osc_in` in NCH: asynchronous oscillator taps; each must toggle slower than `clk`/4.
- `chsel` in $clog2(NCH): channel to measure; sampled only at start.
- `gate_log2` in 5: window length = 2^min(gate_log2, GATE_MAX_LOG2) cycles; sampled only at start.
- `continuous` in 1: 1 = re-gate back-to-back until `stop`; sampled at start.
- `start` in 1: level-sampled request; honoured only in IDLE.
- `stop` in 1: abort; has priority over `start`.
- `busy` out 1: high in ARM and GATE.
- `done` out 1: one-cycle strobe when `result` updates.
- `result` out CNT_W: edge count of the last completed window.
- `overflow` out 1: last completed window saturated.

## Operation
- Each channel is continuously synchronised (2 flops) and edge-detected (third flop, edge = s2 & ~s3) before the channel mux. Channel switching therefore cannot create false edges.
- FSM states: IDLE, ARM, GATE.
- **IDLE**
  - `start`=1 and `stop`=0 → ARM.
  - Latch `chsel`, clamped `gate_log2` and `continuous`.
  - Clear the edge counter, window counter and saturation flag.
- **ARM**: one cycle; no counting → GATE.
- **GATE**
  - Window counter increments each cycle.
  - Selected edge increments the edge counter, saturating at 2^CNT_W−1 and setting the saturation flag.
  - On the last window cycle (window counter = 2^k−1):
    - `result` ← count + edge (saturating).
    - `overflow` ← saturation flag, or saturation occurring on this cycle.
    - `done` ← 1.
  - Then → IDLE if `continuous`=0. Otherwise stay in GATE with both counters cleared, so no edge is lost between windows.
- **stop**
  - In ARM or GATE: → IDLE next cycle.
  - No `done`; `result`/`overflow` keep their previous values.
  - `stop` on the last GATE cycle wins: no update.
- `start` while busy is ignored. `chsel`/`gate_log2`/`continuous` changes mid-measurement are ignored.
- `gate_log2`=0 gives a 1-cycle window.
- Reset (any time, including mid-window): state IDLE; `busy`=0, `done`=0, `result`=0, `overflow`=0; synchroniser flops 0.

## Timing
- `start` sampled high at edge t → ARM during cycle t+1 → GATE cycles t+2 … t+1+2^k.
- `done`/`result` valid in cycle t+2+2^k; `busy` low in that same cycle (single-shot).
- Continuous: `done` every 2^k cycles, `busy` stays high.
- Input-to-count latency is 3 `clk` cycles (synchroniser + edge flop). Edges arriving in the last 3 cycles of a single-shot window are not counted. Expected error is ±1 edge.
- All outputs are registered.

## Structure
- Package `vgaringosc_pkg` holds:
  - the FSM state enum (IDLE, ARM, GATE);
  - the `GATE_MAX_LOG2` default;
  - the `gate_log2` width constant (5).
- Sub-module `osc_sync_edge`: 1-bit 3-flop synchroniser with rising-edge output, async active-high reset. It is instantiated NCH times via generate.
- Top holds the mux, counters and FSM.

## Test plan
- Reset asserted mid-GATE → all outputs 0 in the same cycle; after release, `start` runs normally.
- `chsel`=1, period 8 `clk` on `osc_in[1]`, other channels toggling at period 6, `gate_log2`=8, single-shot:
  - `done` exactly 258 cycles after `start`;
  - `result` = 32±1, `overflow`=0.
- `gate_log2`=20, period 4 input → `result`=65535, `overflow`=1.
- `gate_log2`=31 → clamped; `done` 2^20+2 cycles after `start`.
- Continuous, `gate_log2`=8, period 8: `done` strobes 256 cycles apart; sum of three results = 96±1.
- Start a window with `result` holding a prior value, then:
  - `stop` at GATE cycle 100 → `busy` low next cycle, no `done`, `result` unchanged.
  - `start` pulsed during GATE and `chsel` changed mid-window → no effect on the running count.
